serial_subtractor: RTL
======================

// Module: serial_subtractor
// PURPOSE
//  Multi-cycle two's-complement subtractor: diff = a - b - b_in, computed S bits per
//  clock through one shared S-bit ripple-borrow slice. It is the inverse of the
//  combinational adder family and serves area-constrained datapaths. It uses a
//  start/ready/done handshake, so a controller FSM can issue one operation at a time.
// PARAMETERS
//  N  16  operand/result width in bits.
//  S  4   bits processed per cycle. N % S must be 0 and 1 <= S <= N; violation is a
//         compile-time $error.
//  L  N/S slice cycles per operation (localparam; not overridable).
// PORTS
//  clk    in   1  rising-edge clock.
//  rst    in   1  asynchronous, active-high reset.
//  start  in   1  request; accepted only on an edge where ready=1.
//  a      in   N  minuend; sampled on the accepting edge only.
//  b      in   N  subtrahend; sampled on the accepting edge only.
//  b_in   in   1  borrow-in; sampled on the accepting edge only.
//  ready  out  1  1 in IDLE; block can accept start.
//  busy   out  1  1 in RUN.
//  done   out  1  one-cycle pulse; result outputs valid from this cycle on.
//  diff   out  N  result; held until the next done.
//  b_out  out  1  borrow out of the MSB (unsigned a < b + b_in).
//  ovf    out  1  signed overflow: a[N-1]!=b[N-1] && diff[N-1]!=a[N-1].
//  zero   out  1  diff == 0.
// BEHAVIOUR
//  - Reset (async assert, any time): state=IDLE, ready=1. busy, done, diff, b_out,
//    ovf, zero and the counter all go to 0, as do the shift/borrow registers.
//  - FSM states and transitions:
//      IDLE -start-> RUN: capture a, b and b_in into shift registers; cnt=0.
//      RUN: each edge computes a slice and increments cnt; stays in RUN while cnt<L-1.
//      RUN -cnt==L-1-> DONE: the final slice computes on this same edge.
//      DONE -> IDLE unconditionally after one cycle.
//  - Slice op in RUN, on each edge:
//      {brw', d[S-1:0]} = A[S-1:0] - B[S-1:0] - brw (S+1-bit subtract);
//      A and B shift right by S; d enters the result shift register from the top;
//      brw <= brw'.
//  - Result load on the RUN->DONE edge:
//      diff <= completed result; b_out <= final brw; ovf and zero computed from the
//      completed result and the captured MSBs.
//      All outputs are registered; none combinational from inputs.
//  - Latency: start accepted at edge k -> done high in the cycle after edge k+L.
//    Next start is accepted at edge k+L+2 at the earliest.
//  - Throughput: one op per L+2 cycles.
//  - start while busy or done=1: ignored, with no effect on the in-flight op.
//  - Operand inputs are don't-care outside the accepting edge.
//  - Held outputs: diff, b_out, ovf and zero hold through IDLE/RUN of the next op,
//    changing only at its DONE load.
//  - S == N: L=1, so RUN lasts one edge; the general rules apply unchanged.
//  - Counter width: $clog2(L) bits, minimum 1. Borrow wraps modulo 2^N; no saturation.
// STRUCTURE
//  - Shared package: state encoding localparams (IDLE=2'd0, RUN=2'd1, DONE=2'd2),
//    plus a CLOG2 function for the counter width.
//  - One sub-module, sub_slice #(S) (d, brw_out, x, y, brw_in): a purely
//    combinational S-bit ripple-borrow chain built from per-bit full subtractors.
//  - The top level holds the FSM, counter, shift registers, borrow flop and output
//    registers.
// TESTING (N=16, S=4 unless stated; L=4)
//  1. a=0x0005, b=0x0003, b_in=0 -> diff=0x0002, b_out=0, ovf=0, zero=0; done exactly
//     L=4 cycles after the accepting edge, one cycle wide.
//  2. a=0x0000, b=0x0001, b_in=0 -> diff=0xFFFF, b_out=1, ovf=0, zero=0.
//  3. a=0x8000, b=0x0001 -> diff=0x7FFF, b_out=0, ovf=1.
//     Then a=0x7FFF, b=0xFFFF -> diff=0x8000, b_out=1, ovf=1.
//  4. a=0x1234, b=0x1233, b_in=1 -> diff=0x0000, zero=1, b_out=0.
//  5. Start op a=0x0010, b=0x0001. Pulse start with a=0xFFFF, b=0 on cycle 2 of RUN.
//     Required: done reports diff=0x000F; the second request is ignored.
//     Then assert rst mid-RUN of a new op: all outputs read 0 and ready=1 immediately.
//     No done follows.
//  6. Rebuild with S=1 and S=16, rerunning scenarios 1-4: done at 16 and 1 cycles
//     after accept, with identical results.
//     Also a 2000-op random compare vs a-b-b_in.

Source files
------------

// File: rtl/serial_subtractor_pkg.sv
// Shared types and helpers for the serial subtractor: FSM state encoding and
// the counter-width function.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  // Ceiling log2, never below 1 so a single-slice counter still has a bit.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) begin
      r++;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Operation bus for the serial subtractor: start request, operands, handshake
// status and registered results.
interface serial_subtractor_if #(
  parameter int unsigned N = 16
);
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         b_in;
  logic         ready;
  logic         busy;
  logic         done;
  logic [N-1:0] diff;
  logic         b_out;
  logic         ovf;
  logic         zero;

  modport master (
    output start, a, b, b_in,
    input  ready, busy, done, diff, b_out, ovf, zero
  );

  modport slave (
    input  start, a, b, b_in,
    output ready, busy, done, diff, b_out, ovf, zero
  );

endinterface

// File: rtl/sub_slice.sv
// Combinational S-bit ripple-borrow subtract slice: {brw_out, d} = x - y - brw_in,
// built from one full subtractor per bit.
module sub_slice #(
  parameter int unsigned S = 4
) (
  output logic [S-1:0] d,
  output logic         brw_out,
  input  logic [S-1:0] x,
  input  logic [S-1:0] y,
  input  logic         brw_in
);

  logic [S:0] brw;

  assign brw[0] = brw_in;

  for (genvar i = 0; i < S; i++) begin : g_bit
    assign d[i]       = x[i] ^ y[i] ^ brw[i];
    // Borrow when x < y, or when they are equal and a borrow ripples in.
    assign brw[i+1]   = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & brw[i]);
  end

  assign brw_out = brw[S];

endmodule

// File: rtl/serial_subtractor.sv
// Multi-cycle subtractor: diff = a - b - b_in, S bits per clock through one shared
// slice, with a start/ready/done handshake and registered, held results.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int unsigned N = 16,
  parameter int unsigned S = 4
) (
  input logic                clk,
  input logic                rst,
  serial_subtractor_if.slave bus
);

  localparam int unsigned L    = (S == 0) ? 1 : N / S;
  localparam int unsigned CntW = clog2(L);

  if (S < 1 || S > N) begin : g_bad_s
    $error("serial_subtractor: S must satisfy 1 <= S <= N");
  end else if ((N % S) != 0) begin : g_bad_div
    $error("serial_subtractor: N must be a multiple of S");
  end

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [N-1:0]    a_q;
  logic [N-1:0]    b_q;
  logic [N-1:0]    res_q;
  logic            brw_q;
  logic            a_msb_q;
  logic            b_msb_q;
  logic [N-1:0]    diff_q;
  logic            b_out_q;
  logic            ovf_q;
  logic            zero_q;
  logic            ready_q;
  logic            busy_q;
  logic            done_q;

  logic [S-1:0]    slice_d;
  logic            brw_nxt;
  logic [N-1:0]    res_full;

  sub_slice #(
    .S (S)
  ) u_slice (
    .d       (slice_d),
    .brw_out (brw_nxt),
    .x       (a_q[S-1:0]),
    .y       (b_q[S-1:0]),
    .brw_in  (brw_q)
  );

  // New slice enters from the top, so after L slices the LSB slice sits at bit 0.
  if (S == N) begin : g_res_single
    assign res_full = slice_d;
  end else begin : g_res_shift
    assign res_full = {slice_d, res_q[N-1:S]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      brw_q   <= 1'b0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      diff_q  <= '0;
      b_out_q <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            a_q     <= bus.a;
            b_q     <= bus.b;
            brw_q   <= bus.b_in;
            a_msb_q <= bus.a[N-1];
            b_msb_q <= bus.b[N-1];
            cnt_q   <= '0;
            state_q <= StRun;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        StRun: begin
          a_q   <= a_q >> S;
          b_q   <= b_q >> S;
          res_q <= res_full;
          brw_q <= brw_nxt;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CntW'(L - 1)) begin
            state_q <= StDone;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            diff_q  <= res_full;
            b_out_q <= brw_nxt;
            ovf_q   <= (a_msb_q != b_msb_q) && (res_full[N-1] != a_msb_q);
            zero_q  <= (res_full == '0);
          end
        end
        StDone: begin
          state_q <= StIdle;
          done_q  <= 1'b0;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= StIdle;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ready = ready_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.diff  = diff_q;
  assign bus.b_out = b_out_q;
  assign bus.ovf   = ovf_q;
  assign bus.zero  = zero_q;

endmodule
